// File: rtl/display_sweep_ctrl.sv
// Purpose: time-shares one two-digit BCD split converter across NUM_CH readings, filling a per-channel digit bank.
// Latency: a sweep takes NUM_CH*(SETTLE+2) cycles and starts every REFRESH enabled cycles; bank entry k updates as channel k is captured.
// Backpressure: none; the converter must settle within SETTLE cycles, and a refresh tick arriving mid-sweep is dropped.
module display_sweep_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int SETTLE  = 5,
  parameter int REFRESH = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH*8-1:0] ch_value,
  output logic [7:0]          conv_value,
  input  logic [3:0]          conv_split1,
  input  logic [3:0]          conv_split0,
  output logic [NUM_CH*8-1:0] digits,
  output logic [NUM_CH-1:0]   ovf,
  output logic                busy,
  output logic                sweep_done
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(SETTLE - 1);
  localparam logic [RW-1:0] LAST_REF  = RW'(REFRESH - 1);
  localparam logic [7:0]    OVF_LIMIT = 8'd100;
  // Digit pair that the display scanner renders as two blank digits
  localparam logic [7:0]    BLANK     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    CAPTURE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ch_idx_q, ch_idx_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [RW-1:0] ref_q;
  logic          tick;
  logic          load_en;
  logic          capture_en;
  logic          done_d;

  // The refresh tick fires on the wrap of the counter; it only matters in IDLE
  assign tick = enable && (ref_q == LAST_REF);

  // Refresh counter: runs 0..REFRESH-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (!enable || tick) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_q + RW'(1);
    end
  end

  // Sweep FSM state, channel index and settle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_idx_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      wait_q   <= wait_d;
    end
  end

  // Sweep FSM next-state and datapath strobes
  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    wait_d     = wait_q;
    load_en    = 1'b0;
    capture_en = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          ch_idx_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // conv_value is frozen here so the converter pipeline can drain
        if (wait_q == LAST_WAIT) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        if (ch_idx_q == LAST_CH) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ch_idx_d = ch_idx_q + CW'(1);
          state_d  = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Converter operand, digit bank, overflow flags and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_value <= '0;
      digits     <= '0;
      ovf        <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      busy       <= (state_d != IDLE);
      sweep_done <= done_d;
      if (load_en) begin
        conv_value <= ch_value[int'(ch_idx_q)*8 +: 8];
      end
      if (capture_en) begin
        // Values of 100 and above do not fit two digits: blank them and flag overflow
        if (conv_value < OVF_LIMIT) begin
          digits[int'(ch_idx_q)*8 +: 8] <= {conv_split1, conv_split0};
          ovf[ch_idx_q]                 <= 1'b0;
        end else begin
          digits[int'(ch_idx_q)*8 +: 8] <= BLANK;
          ovf[ch_idx_q]                 <= 1'b1;
        end
      end
    end
  end

endmodule
